// File: rtl/note_sequencer.sv
// Note sequencer: a FIFO of {tone, duration} notes played out as tone/enable to a wave
// generator, timed in prescaled ticks with a silent articulation gap after every note.
module note_sequencer #(
  parameter int unsigned FREQ      = 24000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_valid,
  input  logic [6:0] note_tone,
  input  logic [7:0] note_dur,
  output logic       note_ready,
  input  logic       run,
  input  logic       flush,
  output logic [6:0] tone,
  output logic       en,
  output logic       busy,
  output logic [3:0] level_cnt,
  output logic       done
);

  localparam int unsigned PRESCALE = FREQ / TICK_HZ;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW       = 4;
  localparam int unsigned TW       = 7;
  localparam int unsigned DW       = 8;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t            state, state_nxt;
  logic [TW+DW-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     presc;
  logic [DW-1:0]     ticks, ticks_nxt;
  logic [TW-1:0]     tone_nxt, head_tone;
  logic [DW-1:0]     head_dur;
  logic              en_nxt, busy_nxt, done_nxt;
  logic              wr_c, pop_c, take_c, clr_c, fetch_c, have_c, tick_c;

  // FIFO accepts only from registered occupancy, so a full FIFO refuses even on a pop cycle
  assign note_ready = (level_cnt < LW'(DEPTH)) && !flush;
  assign wr_c       = note_valid && note_ready;
  assign head_tone  = mem[rd_ptr][TW+DW-1:DW];
  assign head_dur   = mem[rd_ptr][DW-1:0];
  assign have_c     = run && (level_cnt != '0) && !flush;
  assign tick_c     = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= {note_tone, note_dur};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_cnt <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_cnt <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      if (wr_c && !pop_c)      level_cnt <= level_cnt + LW'(1);
      else if (!wr_c && pop_c) level_cnt <= level_cnt - LW'(1);
    end
  end

  // State, timing counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      ticks <= '0;
      tone  <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ticks <= ticks_nxt;
      tone  <= tone_nxt;
      en    <= en_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (clr_c || tick_c || (state_nxt != state) || (state == IDLE)) presc <= '0;
      else                                                            presc <= presc + PW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    ticks_nxt = ticks;
    tone_nxt  = tone;
    en_nxt    = en;
    done_nxt  = 1'b0;
    pop_c     = 1'b0;
    take_c    = 1'b0;
    clr_c     = 1'b0;
    fetch_c   = 1'b0;
    case (state)
      IDLE: take_c = have_c;
      PLAY, GAP: begin
        if (!run) begin
          state_nxt = IDLE;
          tone_nxt  = '0;
          en_nxt    = 1'b0;
        end else if (tick_c) begin
          if (ticks == DW'(1)) begin
            if ((state == PLAY) && (GAP_TICKS != 0)) begin
              state_nxt = GAP;
              en_nxt    = 1'b0;
              ticks_nxt = DW'(GAP_TICKS);
              clr_c     = 1'b1;
            end else begin
              fetch_c = 1'b1;
            end
          end else begin
            ticks_nxt = ticks - DW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tone_nxt  = '0;
        en_nxt    = 1'b0;
      end
    endcase
    // End of a note: fall silent unless another entry is ready to load
    if (fetch_c) begin
      state_nxt = IDLE;
      tone_nxt  = '0;
      en_nxt    = 1'b0;
      clr_c     = 1'b1;
      take_c    = have_c;
      done_nxt  = !have_c;
    end
    // Zero-length entries are popped and dropped without touching the outputs
    if (take_c) begin
      pop_c = 1'b1;
      if (head_dur != '0) begin
        state_nxt = PLAY;
        tone_nxt  = head_tone;
        en_nxt    = (head_tone != '0);
        ticks_nxt = head_dur;
        clr_c     = 1'b1;
      end
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with PRESCALE=4, DEPTH=8, GAP_TICKS=1.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst, note_valid, run, flush;
  logic [6:0] note_tone;
  logic [7:0] note_dur;
  logic       note_ready, en, busy, done;
  logic [6:0] tone;
  logic [3:0] level_cnt;

  int vectors = 0;
  int miscompares = 0;

  note_sequencer #(.FREQ(40), .TICK_HZ(10), .DEPTH(8), .GAP_TICKS(1)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_tone(note_tone),
    .note_dur(note_dur), .note_ready(note_ready), .run(run), .flush(flush),
    .tone(tone), .en(en), .busy(busy), .level_cnt(level_cnt), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_note(input logic [6:0] t, input logic [7:0] d);
    note_valid = 1'b1;
    note_tone  = t;
    note_dur   = d;
    step();
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; note_valid = 1'b0; note_tone = '0; note_dur = '0; run = 1'b0; flush = 1'b0;
    step(); step();
    vectors++;
    if ({en, busy, done, tone, level_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b tone=%0d lvl=%0d expected all 0",
               en, busy, done, tone, level_cnt);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (note_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", note_ready);
    end
  endtask

  task automatic test_single_note();
    run = 1'b1;
    write_note(7'd40, 8'd3);
    vectors++;
    if (level_cnt !== 4'd1 || en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_accept: got lvl=%0d en=%b expected lvl=1 en=0", level_cnt, en);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({en, tone, busy} !== {1'b1, 7'd40, 1'b1}) begin
        miscompares++;
        $display("FAIL single_play[%0d]: got en=%b tone=%0d busy=%b expected en=1 tone=40 busy=1",
                 i, en, tone, busy);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({en, tone, busy, done} !== {1'b0, 7'd40, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL single_gap[%0d]: got en=%b tone=%0d busy=%b done=%b expected en=0 tone=40 busy=1 done=0",
                 i, en, tone, busy, done);
      end
      step();
    end
    vectors++;
    if ({done, busy, tone} !== {1'b1, 1'b0, 7'd0}) begin
      miscompares++;
      $display("FAIL single_done: got done=%b busy=%b tone=%0d expected done=1 busy=0 tone=0",
               done, busy, tone);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_fifo_order();
    run = 1'b0;
    for (int k = 0; k < 8; k++) write_note(7'(11 + k), 8'd1);
    vectors++;
    if (level_cnt !== 4'd8 || note_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full: got lvl=%0d ready=%b expected lvl=8 ready=0", level_cnt, note_ready);
    end
    write_note(7'd99, 8'd1);
    vectors++;
    if (level_cnt !== 4'd8) begin
      miscompares++;
      $display("FAIL fifo_ninth: got lvl=%0d expected 8", level_cnt);
    end
    // A write offered on the same edge as the first pop must still be refused
    note_valid = 1'b1; note_tone = 7'd99; run = 1'b1;
    step();
    note_valid = 1'b0;
    vectors++;
    if (level_cnt !== 4'd7) begin
      miscompares++;
      $display("FAIL fifo_full_pop: got lvl=%0d expected 7", level_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if ({en, tone} !== {1'b1, 7'(11 + k)}) begin
        miscompares++;
        $display("FAIL fifo_order_play[%0d]: got en=%b tone=%0d expected en=1 tone=%0d", k, en, tone, 11 + k);
      end
      repeat (4) step();
      vectors++;
      if ({en, tone} !== {1'b0, 7'(11 + k)}) begin
        miscompares++;
        $display("FAIL fifo_order_gap[%0d]: got en=%b tone=%0d expected en=0 tone=%0d", k, en, tone, 11 + k);
      end
      repeat (4) step();
    end
    vectors++;
    if ({done, busy, tone, level_cnt} !== {1'b1, 1'b0, 7'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL fifo_drain: got done=%b busy=%b tone=%0d lvl=%0d expected done=1 busy=0 tone=0 lvl=0",
               done, busy, tone, level_cnt);
    end
  endtask

  task automatic test_rest_and_zero();
    run = 1'b1;
    write_note(7'd0, 8'd2);
    write_note(7'd49, 8'd1);
    vectors++;
    if ({busy, en, tone, level_cnt} !== {1'b1, 1'b0, 7'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL rest_start: got busy=%b en=%b tone=%0d lvl=%0d expected busy=1 en=0 tone=0 lvl=1",
               busy, en, tone, level_cnt);
    end
    repeat (7) step();
    vectors++;
    if ({busy, en} !== 2'b10) begin
      miscompares++;
      $display("FAIL rest_end: got busy=%b en=%b expected busy=1 en=0", busy, en);
    end
    repeat (5) step();
    vectors++;
    if ({en, tone} !== {1'b1, 7'd49}) begin
      miscompares++;
      $display("FAIL rest_next: got en=%b tone=%0d expected en=1 tone=49", en, tone);
    end
    repeat (3) step();
    vectors++;
    if ({en, tone} !== {1'b1, 7'd49}) begin
      miscompares++;
      $display("FAIL rest_next_hold: got en=%b tone=%0d expected en=1 tone=49", en, tone);
    end
    repeat (5) step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL rest_done: got %b expected 1", done);
    end
    write_note(7'd10, 8'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({level_cnt, busy, en, tone, done} !== {4'd0, 1'b0, 1'b0, 7'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL zero_dur[%0d]: got lvl=%0d busy=%b en=%b tone=%0d done=%b expected all 0",
                 i, level_cnt, busy, en, tone, done);
      end
      step();
    end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    write_note(7'd20, 8'd5);
    write_note(7'd21, 8'd1);
    write_note(7'd22, 8'd1);
    run = 1'b1;
    step();
    vectors++;
    if ({en, tone, level_cnt} !== {1'b1, 7'd20, 4'd2}) begin
      miscompares++;
      $display("FAIL drop_play: got en=%b tone=%0d lvl=%0d expected en=1 tone=20 lvl=2", en, tone, level_cnt);
    end
    repeat (5) step();
    run = 1'b0;
    step();
    vectors++;
    if ({en, tone, busy, done, level_cnt} !== {1'b0, 7'd0, 1'b0, 1'b0, 4'd2}) begin
      miscompares++;
      $display("FAIL drop_stop: got en=%b tone=%0d busy=%b done=%b lvl=%0d expected en=0 tone=0 busy=0 done=0 lvl=2",
               en, tone, busy, done, level_cnt);
    end
    step();
    vectors++;
    if ({done, level_cnt} !== {1'b0, 4'd2}) begin
      miscompares++;
      $display("FAIL drop_no_done: got done=%b lvl=%0d expected done=0 lvl=2", done, level_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (level_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL drop_flush: got lvl=%0d expected 0", level_cnt);
    end
  endtask

  task automatic test_flush();
    run = 1'b1;
    write_note(7'd30, 8'd2);
    write_note(7'd31, 8'd1);
    write_note(7'd32, 8'd1);
    write_note(7'd33, 8'd1);
    vectors++;
    if (level_cnt !== 4'd3) begin
      miscompares++;
      $display("FAIL flush_queued: got lvl=%0d expected 3", level_cnt);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (note_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %b expected 0", note_ready);
    end
    step();
    flush = 1'b0;
    vectors++;
    if ({level_cnt, en, tone} !== {4'd0, 1'b1, 7'd30}) begin
      miscompares++;
      $display("FAIL flush_level: got lvl=%0d en=%b tone=%0d expected lvl=0 en=1 tone=30", level_cnt, en, tone);
    end
    repeat (4) step();
    vectors++;
    if ({en, tone} !== {1'b1, 7'd30}) begin
      miscompares++;
      $display("FAIL flush_continue: got en=%b tone=%0d expected en=1 tone=30", en, tone);
    end
    step();
    vectors++;
    if ({en, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_gap: got en=%b busy=%b expected en=0 busy=1", en, busy);
    end
    repeat (4) step();
    vectors++;
    if ({done, busy, tone} !== {1'b1, 1'b0, 7'd0}) begin
      miscompares++;
      $display("FAIL flush_done: got done=%b busy=%b tone=%0d expected done=1 busy=0 tone=0", done, busy, tone);
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    write_note(7'd50, 8'd4);
    write_note(7'd51, 8'd1);
    write_note(7'd52, 8'd1);
    vectors++;
    if ({en, level_cnt} !== {1'b1, 4'd2}) begin
      miscompares++;
      $display("FAIL rstmid_pre: got en=%b lvl=%0d expected en=1 lvl=2", en, level_cnt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({en, level_cnt, busy, tone} !== {1'b0, 4'd0, 1'b0, 7'd0}) begin
      miscompares++;
      $display("FAIL rstmid_async: got en=%b lvl=%0d busy=%b tone=%0d expected all 0", en, level_cnt, busy, tone);
    end
    step();
    rst = 1'b0;
    write_note(7'd60, 8'd1);
    step();
    vectors++;
    if ({en, tone} !== {1'b1, 7'd60}) begin
      miscompares++;
      $display("FAIL rstmid_replay: got en=%b tone=%0d expected en=1 tone=60", en, tone);
    end
    repeat (8) step();
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_fifo_order();
    test_rest_and_zero();
    test_run_drop();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
